mul_div_unit: RTL
=================

# mul_div_unit

Parametrised iterative multiply/divide unit serving the EX stage for MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV and DIVU. It replaces the single-cycle multiplier, the two-cycle accumulate sequencing done in EX, and the separate divider with one start/done engine. EX holds its stall request while `o_ready` is low. EX writes HI/LO from `o_hi`/`o_lo` on `o_done`.

## Interface
Parameters:
- N_DATA, 32, operand width; HI/LO are N_DATA each.
- MUL_BPC, 2, multiplier bits retired per cycle; power of 2, divides N_DATA.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  request; accepted only when o_ready=1 and i_annul=0.
- i_op  in  3  operation, encoded by mdu_op_e.
- i_op_a  in  N_DATA  multiplicand / dividend, sampled at accept.
- i_op_b  in  N_DATA  multiplier / divisor, sampled at accept.
- i_hi, i_lo  in  N_DATA  accumulator base for MADD*/MSUB*, sampled at accept.
- i_annul  in  1  flush (exception/branch kill); aborts in-flight op.
- o_ready  out  1  unit idle and able to accept.
- o_done  out  1  one-cycle result-valid pulse.
- o_hi, o_lo  out  N_DATA  result: product/accumulate high/low, or remainder/quotient.
- o_div_by_zero  out  1  qualifies o_done for DIV/DIVU with divisor 0.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE: o_ready=1. On accept, load operand registers. Signed ops load magnitudes and record the result sign. Next state is MUL for multiply ops, DIV for divide ops, or FIX directly if a divide has divisor 0.
- MUL: shift-add, MUL_BPC multiplier bits per cycle, for N_DATA/MUL_BPC cycles into a 2·N_DATA product register.
- DIV: restoring division, 1 quotient bit per cycle, for N_DATA cycles.
- FIX: one cycle of sign correction, then accumulate:
  - signed multiply: negate the 2N product if the operand signs differ.
  - MADD*: result = {hi,lo} + product.
  - MSUB*: result = {hi,lo} − product.
  - accumulate arithmetic is modulo 2^(2·N_DATA).
  - signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - results are registered into o_hi/o_lo.
- DONE: o_done=1 for one cycle, then IDLE.
- Width rules:
  - most-negative ÷ −1 gives quotient 0x80000000, remainder 0.
  - divide by 0 gives quotient all-ones, remainder = i_op_a, and o_div_by_zero=1.
- i_start while not ready is ignored. The caller must hold its request until o_ready.
- i_annul in MUL, DIV, FIX or DONE sends the FSM to IDLE next edge. o_done is forced 0 that cycle, and o_hi/o_lo keep their prior values.
- i_start together with i_annul in IDLE is not accepted.

## Timing
- Reset: state=IDLE, o_ready=1, o_done=0, o_div_by_zero=0, o_hi=o_lo=0, all internal registers 0. Reset asserted mid-operation discards the operation.
- Cycle 0 is the accept cycle:
  - multiply ops: o_done in cycle N_DATA/MUL_BPC+2 (cycle 18 at defaults).
  - divide ops: o_done in cycle N_DATA+2 (cycle 34).
  - divide by zero: o_done in cycle 2.
- o_ready is low from cycle 1 through the o_done cycle and high the cycle after. Back-to-back throughput is one op per latency+1 cycles.
- o_done, o_hi, o_lo and o_div_by_zero are registered. o_hi/o_lo hold until the next o_done. o_div_by_zero holds until the next accept.
- o_ready is decoded from the state register only.

## Structure
- Package mdu_pkg holds:
  - mdu_op_e: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7.
  - the mdu_state_e enum.
  - helper functions is_signed(op), is_div(op), is_acc(op).
- One sub-module, mdu_div_step: a combinational restoring step taking {partial remainder, dividend bit, divisor} and returning {next remainder, quotient bit}.
- Parameter checks in an initial assertion: MUL_BPC power of 2 and N_DATA % MUL_BPC == 0.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → o_done at cycle 18, hi=0xFFFFFFFF, lo=0xFFFFFFFA; o_ready low cycles 1–18.
- MADDU hi=0, lo=0xFFFFFFFF, a=1, b=1 → hi=0x00000001, lo=0x00000000 (carry across halves).
- MSUB hi=0, lo=5, a=2, b=3 → hi=lo=0xFFFFFFFF; then MULTU 0xFFFFFFFF×0xFFFFFFFF back-to-back → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9, b=2 → o_done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=10, b=0 → o_done at cycle 2, o_div_by_zero=1, lo=0xFFFFFFFF, hi=0x0000000A.
- DIV annulled at cycle 5 → no o_done, o_ready=1 at cycle 6, o_hi/o_lo unchanged. i_rst_n pulsed low mid-MUL → outputs immediately at reset values.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the
// iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_e;

  function automatic logic is_signed(mdu_op_e op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_acc(mdu_op_e op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(mdu_op_e op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-side request/result bundle of the
// multiply/divide unit.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int N_DATA = 32
);
  logic              i_start;
  mdu_op_e           i_op;
  logic [N_DATA-1:0] i_op_a;
  logic [N_DATA-1:0] i_op_b;
  logic [N_DATA-1:0] i_hi;
  logic [N_DATA-1:0] i_lo;
  logic              i_annul;
  logic              o_ready;
  logic              o_done;
  logic [N_DATA-1:0] o_hi;
  logic [N_DATA-1:0] o_lo;
  logic              o_div_by_zero;

  modport slave (
    input  i_start, i_op, i_op_a, i_op_b,
    input  i_hi, i_lo, i_annul,
    output o_ready, o_done, o_hi, o_lo,
    output o_div_by_zero
  );

  modport master (
    output i_start, i_op, i_op_a, i_op_b,
    output i_hi, i_lo, i_annul,
    input  o_ready, o_done, o_hi, o_lo,
    input  o_div_by_zero
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a
// dividend bit, trial-subtract the divisor.
module mdu_div_step #(
  parameter int N_DATA = 32
) (
  input  logic [N_DATA-1:0] i_rem,
  input  logic              i_bit,
  input  logic [N_DATA-1:0] i_div,
  output logic [N_DATA-1:0] o_rem,
  output logic              o_q
);
  logic [N_DATA:0] w_sh;
  logic [N_DATA:0] w_diff;

  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh - {1'b0, i_div};
  assign o_q    = (w_sh >= {1'b0, i_div});
  assign o_rem  = o_q ? w_diff[N_DATA-1:0]
                      : w_sh[N_DATA-1:0];
endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring
// divider with MADD/MSUB accumulate for EX.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int N_DATA  = 32,
  parameter int MUL_BPC = 2
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  mdu_if.slave  bus
);
  localparam int NM = N_DATA / MUL_BPC;
  localparam int CW = $clog2(N_DATA + 1);
  localparam int W2 = 2 * N_DATA;
  localparam int WP = N_DATA + MUL_BPC;

  if (MUL_BPC <= 0 || (MUL_BPC & (MUL_BPC - 1)) != 0 ||
      (N_DATA % MUL_BPC) != 0) begin : g_bad_param
    $error("mul_div_unit: illegal MUL_BPC");
  end

  mdu_state_e        r_state, w_next;
  mdu_op_e           r_op;
  logic              r_neg, r_rneg, r_dz;
  logic              r_done, r_dbz;
  logic [N_DATA-1:0] r_a, r_hi, r_lo;
  logic [W2-1:0]     r_prod, r_acc;
  logic [CW-1:0]     r_cnt;

  logic              w_accept, w_sgn, w_b_zero;
  logic              w_a_neg, w_b_neg;
  logic [N_DATA-1:0] w_a_mag, w_b_mag;
  logic [WP-1:0]     w_pp, w_mul_hi;
  logic [W2-1:0]     w_mul_nx, w_div_nx;
  logic [W2-1:0]     w_p, w_mres, w_fix;
  logic [N_DATA-1:0] w_rem_nx, w_qf, w_rf;
  logic              w_q;

  assign bus.o_ready       = (r_state == S_IDLE);
  assign bus.o_done        = r_done & ~bus.i_annul;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;
  assign bus.o_div_by_zero = r_dbz;

  assign w_accept = bus.o_ready & bus.i_start & ~bus.i_annul;
  assign w_sgn    = is_signed(bus.i_op);
  assign w_b_zero = (bus.i_op_b == '0);
  assign w_a_neg  = w_sgn & bus.i_op_a[N_DATA-1];
  assign w_b_neg  = w_sgn & bus.i_op_b[N_DATA-1];
  assign w_a_mag  = w_a_neg ? -bus.i_op_a : bus.i_op_a;
  assign w_b_mag  = w_b_neg ? -bus.i_op_b : bus.i_op_b;

  // Low half of r_prod holds the multiplier being
  // consumed; high half accumulates partial sums.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (r_prod[j]) w_pp = w_pp + ({{MUL_BPC{1'b0}}, r_a} << j);
    end
  end

  assign w_mul_hi = {{MUL_BPC{1'b0}}, r_prod[W2-1:N_DATA]} + w_pp;
  assign w_mul_nx = {w_mul_hi, r_prod[N_DATA-1:MUL_BPC]};

  mdu_div_step #(.N_DATA(N_DATA)) u_step (
    .i_rem (r_prod[W2-1:N_DATA]),
    .i_bit (r_prod[N_DATA-1]),
    .i_div (r_a),
    .o_rem (w_rem_nx),
    .o_q   (w_q)
  );

  assign w_div_nx = {w_rem_nx, r_prod[N_DATA-2:0], w_q};

  assign w_p    = r_neg ? -r_prod : r_prod;
  assign w_mres = !is_acc(r_op) ? w_p :
                  is_sub(r_op)  ? r_acc - w_p : r_acc + w_p;
  assign w_qf   = (r_neg & ~r_dz) ? -r_prod[N_DATA-1:0]
                                  : r_prod[N_DATA-1:0];
  assign w_rf   = (r_rneg & ~r_dz) ? -r_prod[W2-1:N_DATA]
                                   : r_prod[W2-1:N_DATA];
  assign w_fix  = is_div(r_op) ? {w_rf, w_qf} : w_mres;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = !is_div(bus.i_op) ? S_MUL :
                   w_b_zero ? S_FIX : S_DIV;
      S_MUL:   if (r_cnt == '0) w_next = S_FIX;
      S_DIV:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && bus.i_annul) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op   <= OP_MULT;
      r_neg  <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_a    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= bus.i_op;
          r_neg  <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          r_acc  <= {bus.i_hi, bus.i_lo};
          r_dz   <= is_div(bus.i_op) & w_b_zero;
          r_dbz  <= is_div(bus.i_op) & w_b_zero;
          if (!is_div(bus.i_op)) begin
            r_a    <= w_a_mag;
            r_prod <= {{N_DATA{1'b0}}, w_b_mag};
            r_cnt  <= CW'(NM - 1);
          end else if (w_b_zero) begin
            r_a    <= '0;
            r_prod <= {bus.i_op_a, {N_DATA{1'b1}}};
            r_cnt  <= '0;
          end else begin
            r_a    <= w_b_mag;
            r_prod <= {{N_DATA{1'b0}}, w_a_mag};
            r_cnt  <= CW'(N_DATA - 1);
          end
        end
        S_MUL: begin
          r_prod <= w_mul_nx;
          r_cnt  <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_prod <= w_div_nx;
          r_cnt  <= r_cnt - CW'(1);
        end
        S_FIX: if (!bus.i_annul) begin
          {r_hi, r_lo} <= w_fix;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
